// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder:
// FSM encoding, default geometry and the counter-width helper.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

    localparam int DEF_LATENCY = 4;
    localparam int DEF_MEM_AW  = 9;
    localparam int DATA_W      = 16;

    function automatic int cnt_width(input int lat);
        int w;
        w = $clog2(lat);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// 2^AW x 16 backing store: synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int AW = DEF_MEM_AW
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_dff.sv
// Enabled D flip-flop cell with synchronous active-high reset,
// used for every piece of FSM and request state in the responder.
module dmem_dff #(
    parameter int          W  = 1,
    parameter logic [W-1:0] RV = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_o <= RV;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder: stalls the memory stage while an
// access is in flight, pulses Done on completion, err on bad requests.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int MEM_AW  = DEF_MEM_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       Addr,
    input  logic [15:0]       DataIn,
    input  logic              Rd,
    input  logic              Wr,
    output logic [15:0]       DataOut,
    output logic              Stall,
    output logic              Done,
    output logic              err
);

    localparam int CW       = cnt_width(LATENCY);
    localparam int CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

    logic [1:0]        state_raw_q;
    dmem_state_e       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [MEM_AW-1:0] addr_q;
    logic [15:0]       data_q;
    logic              wr_q;
    logic [15:0]       dout_q;

    logic              req, illegal, accept;
    logic              commit;
    logic              acc_wr;
    logic [MEM_AW-1:0] acc_addr;
    logic [15:0]       acc_data;
    logic [15:0]       rdata;
    logic              mem_we, dout_en;

    assign state_q = dmem_state_e'(state_raw_q);
    assign req     = Rd | Wr;
    assign illegal = (Rd & Wr) | Addr[0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        commit   = 1'b0;
        Stall    = 1'b0;
        Done     = 1'b0;
        err      = 1'b0;
        acc_wr   = wr_q;
        acc_addr = addr_q;
        acc_data = data_q;
        case (state_q)
            IDLE: begin
                if (req && illegal) begin
                    err = 1'b1;
                end else if (req) begin
                    Stall  = 1'b1;
                    accept = 1'b1;
                    // Single-cycle latency completes on the accept edge itself
                    if (LATENCY == 1) begin
                        commit   = 1'b1;
                        acc_wr   = Wr;
                        acc_addr = Addr[MEM_AW:1];
                        acc_data = DataIn;
                        state_d  = DONE;
                    end else begin
                        cnt_d   = CW'(CNT_INIT);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Gating with rst keeps an aborted store out of the array
    assign mem_we  = commit & acc_wr & ~rst;
    assign dout_en = commit & ~acc_wr;

    dmem_dff #(.W(2), .RV(2'(IDLE))) u_state (
        .clk(clk), .rst(rst), .en_i(1'b1),
        .d_i(2'(state_d)), .q_o(state_raw_q)
    );

    dmem_dff #(.W(CW)) u_cnt (
        .clk(clk), .rst(rst), .en_i(1'b1),
        .d_i(cnt_d), .q_o(cnt_q)
    );

    dmem_dff #(.W(MEM_AW)) u_addr (
        .clk(clk), .rst(rst), .en_i(accept),
        .d_i(Addr[MEM_AW:1]), .q_o(addr_q)
    );

    dmem_dff #(.W(16)) u_data (
        .clk(clk), .rst(rst), .en_i(accept),
        .d_i(DataIn), .q_o(data_q)
    );

    dmem_dff #(.W(1)) u_wr (
        .clk(clk), .rst(rst), .en_i(accept),
        .d_i(Wr), .q_o(wr_q)
    );

    dmem_dff #(.W(16)) u_dout (
        .clk(clk), .rst(rst), .en_i(dout_en),
        .d_i(rdata), .q_o(dout_q)
    );

    dmem_array #(.AW(MEM_AW)) u_array (
        .clk    (clk),
        .we_i   (mem_we),
        .addr_i (acc_addr),
        .wdata_i(acc_data),
        .rdata_o(rdata)
    );

    assign DataOut = dout_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=4 and LATENCY=1 instances
// driven with hand-computed vectors.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;

    logic [15:0] Addr4, Din4, Dout4;
    logic        Rd4, Wr4, Stall4, Done4, Err4;
    logic [15:0] Addr1, Din1, Dout1;
    logic        Rd1, Wr1, Stall1, Done1, Err1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(4), .MEM_AW(9)) u4 (
        .clk(clk), .rst(rst), .Addr(Addr4), .DataIn(Din4),
        .Rd(Rd4), .Wr(Wr4), .DataOut(Dout4), .Stall(Stall4),
        .Done(Done4), .err(Err4)
    );

    dmem_responder #(.LATENCY(1), .MEM_AW(9)) u1 (
        .clk(clk), .rst(rst), .Addr(Addr1), .DataIn(Din1),
        .Rd(Rd1), .Wr(Wr1), .DataOut(Dout1), .Stall(Stall1),
        .Done(Done1), .err(Err1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request on u4 and advance to its Done cycle
    task automatic run4(input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d,
                        output int lat, output int stalls);
        Rd4 = rd; Wr4 = wr; Addr4 = a; Din4 = d;
        #1;
        stalls = 0;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (Stall4) stalls++;
            if (Done4) begin
                lat = i;
                break;
            end
            step();
            Rd4 = 1'b0; Wr4 = 1'b0;
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        Rd4 = 0; Wr4 = 0; Addr4 = 0; Din4 = 0;
        Rd1 = 0; Wr1 = 0; Addr1 = 0; Din1 = 0;
        step(); step();
        rst = 1'b0;
        #1;
        checks++;
        if ({Dout4, Stall4, Done4, Err4} !== 19'h0) begin
            errors++;
            $display("FAIL reset4 got %h/%b%b%b want 0000/000",
                     Dout4, Stall4, Done4, Err4);
        end
        checks++;
        if ({Dout1, Stall1, Done1, Err1} !== 19'h0) begin
            errors++;
            $display("FAIL reset1 got %h/%b%b%b want 0000/000",
                     Dout1, Stall1, Done1, Err1);
        end
        step();
        checks++;
        if ({Stall4, Done4, Err4} !== 3'b000) begin
            errors++;
            $display("FAIL idle4 got %b%b%b want 000", Stall4, Done4, Err4);
        end
    endtask

    task automatic test_store_load();
        int lat, st;
        step();
        run4(1'b0, 1'b1, 16'h0010, 16'hBEEF, lat, st);
        checks++;
        if (lat !== 4 || st !== 4) begin
            errors++;
            $display("FAIL store_timing got lat=%0d stall=%0d want 4/4", lat, st);
        end
        checks++;
        if (Dout4 !== 16'h0000 || Stall4 !== 1'b0) begin
            errors++;
            $display("FAIL store_done got dout=%h stall=%b want 0000/0", Dout4, Stall4);
        end
        step();
        run4(1'b1, 1'b0, 16'h0010, 16'h0000, lat, st);
        checks++;
        if (lat !== 4 || st !== 4) begin
            errors++;
            $display("FAIL load_timing got lat=%0d stall=%0d want 4/4", lat, st);
        end
        checks++;
        if (Dout4 !== 16'hBEEF) begin
            errors++;
            $display("FAIL load_data got %h want beef", Dout4);
        end
        step();
        checks++;
        if (Done4 !== 1'b0 || Dout4 !== 16'hBEEF) begin
            errors++;
            $display("FAIL done_pulse got done=%b dout=%h want 0/beef", Done4, Dout4);
        end
    endtask

    task automatic test_misaligned();
        int dones;
        Rd4 = 1'b1; Addr4 = 16'h0011;
        #1;
        checks++;
        if (Err4 !== 1'b1 || Stall4 !== 1'b0) begin
            errors++;
            $display("FAIL misalign got err=%b stall=%b want 1/0", Err4, Stall4);
        end
        step();
        Rd4 = 1'b0;
        #1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (Done4 || Err4 || Stall4) dones++;
            step();
        end
        checks++;
        if (dones !== 0 || Dout4 !== 16'hBEEF) begin
            errors++;
            $display("FAIL misalign_quiet got act=%0d dout=%h want 0/beef", dones, Dout4);
        end
    endtask

    task automatic test_rd_wr_both();
        int lat, st;
        run4(1'b0, 1'b1, 16'h0020, 16'h5555, lat, st);
        step();
        Rd4 = 1'b1; Wr4 = 1'b1; Addr4 = 16'h0020; Din4 = 16'h1111;
        #1;
        checks++;
        if (Err4 !== 1'b1 || Stall4 !== 1'b0) begin
            errors++;
            $display("FAIL rdwr_err got err=%b stall=%b want 1/0", Err4, Stall4);
        end
        step();
        Rd4 = 1'b0; Wr4 = 1'b0;
        #1;
        checks++;
        if (Err4 !== 1'b0 || Stall4 !== 1'b0) begin
            errors++;
            $display("FAIL rdwr_pulse got err=%b stall=%b want 0/0", Err4, Stall4);
        end
        run4(1'b1, 1'b0, 16'h0020, 16'h0000, lat, st);
        checks++;
        if (lat !== 4 || Dout4 !== 16'h5555) begin
            errors++;
            $display("FAIL rdwr_prior got lat=%0d dout=%h want 4/5555", lat, Dout4);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int dones;
        int first_done;
        int second_done;
        dones = 0; first_done = -1; second_done = -1;
        Rd4 = 1'b1; Addr4 = 16'h0010;
        #1;
        for (int i = 0; i < 12; i++) begin
            if (Done4) begin
                dones++;
                if (first_done < 0) first_done = i;
                else second_done = i;
            end
            if (i == 4) begin
                checks++;
                if (Stall4 !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_done_stall got %b want 0", Stall4);
                end
            end
            if (i == 5) begin
                checks++;
                if (Stall4 !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_reaccept got %b want 1", Stall4);
                end
            end
            step();
            if (i >= 5) Rd4 = 1'b0;
            #1;
        end
        checks++;
        if (dones !== 2 || first_done !== 4 || second_done !== 9) begin
            errors++;
            $display("FAIL hold_dones got n=%0d at %0d,%0d want 2 at 4,9",
                     dones, first_done, second_done);
        end
        checks++;
        if (Dout4 !== 16'hBEEF) begin
            errors++;
            $display("FAIL hold_data got %h want beef", Dout4);
        end
    endtask

    task automatic test_reset_midop();
        int lat, st;
        int act;
        run4(1'b0, 1'b1, 16'h0030, 16'hA5A5, lat, st);
        step();
        Wr4 = 1'b1; Addr4 = 16'h0030; Din4 = 16'h1234;
        step();
        Wr4 = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({Dout4, Stall4, Done4, Err4} !== 19'h0) begin
            errors++;
            $display("FAIL midrst_out got %h/%b%b%b want 0000/000",
                     Dout4, Stall4, Done4, Err4);
        end
        act = 0;
        for (int i = 0; i < 6; i++) begin
            if (Done4 || Stall4) act++;
            step();
        end
        checks++;
        if (act !== 0) begin
            errors++;
            $display("FAIL midrst_quiet got %0d want 0", act);
        end
        run4(1'b1, 1'b0, 16'h0030, 16'h0000, lat, st);
        checks++;
        if (lat !== 4 || Dout4 !== 16'hA5A5) begin
            errors++;
            $display("FAIL midrst_old got lat=%0d dout=%h want 4/a5a5", lat, Dout4);
        end
        step();
    endtask

    task automatic test_latency1_alias();
        Wr1 = 1'b1; Addr1 = 16'h0000; Din1 = 16'h00AA;
        #1;
        checks++;
        if (Stall1 !== 1'b1 || Done1 !== 1'b0) begin
            errors++;
            $display("FAIL l1_accept got stall=%b done=%b want 1/0", Stall1, Done1);
        end
        step();
        Wr1 = 1'b0;
        #1;
        checks++;
        if (Done1 !== 1'b1 || Stall1 !== 1'b0) begin
            errors++;
            $display("FAIL l1_store_done got done=%b stall=%b want 1/0", Done1, Stall1);
        end
        step();
        Rd1 = 1'b1; Addr1 = 16'h0400;
        #1;
        checks++;
        if (Stall1 !== 1'b1) begin
            errors++;
            $display("FAIL l1_load_stall got %b want 1", Stall1);
        end
        step();
        Rd1 = 1'b0;
        #1;
        checks++;
        if (Done1 !== 1'b1 || Dout1 !== 16'h00AA) begin
            errors++;
            $display("FAIL l1_alias got done=%b dout=%h want 1/00aa", Done1, Dout1);
        end
        step();
        checks++;
        if (Done1 !== 1'b0 || Stall1 !== 1'b0 || Dout1 !== 16'h00AA) begin
            errors++;
            $display("FAIL l1_after got done=%b stall=%b dout=%h want 0/0/00aa",
                     Done1, Stall1, Dout1);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_misaligned();
        test_rd_wr_both();
        test_back_to_back();
        test_reset_midop();
        test_latency1_alias();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
